// File: rtl/adsb_squitter_encoder.sv
// ADS-B extended squitter transmit encoder.
// Takes one 112-bit squitter per input transfer and streams the 64 MSps
// pulse-position magnitude waveform: a 16-chip preamble followed by
// 112 Manchester-coded bits, 32 samples per chip, 7680 samples per frame.
// Optional build macro ADSB_ENC_CRC_EN: transmit only the 88-bit payload from
// the input and append an internally generated CRC-24 parity field.
`timescale 1ns/1ps

module adsb_squitter_encoder #(
    parameter int SQUITTER_LENGTH        = 112,
    parameter int CHIP_LENGTH            = 32,
    parameter int PREAMBLE_CHIPS         = 16,
    parameter int C_S00_AXIS_TDATA_WIDTH = SQUITTER_LENGTH,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tx_amplitude,
    output logic                              busy
);

    localparam int SW = $clog2(CHIP_LENGTH);
    localparam int CW = $clog2(PREAMBLE_CHIPS);
    localparam int BW = $clog2(SQUITTER_LENGTH);

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(CHIP_LENGTH - 1);
    localparam logic [CW-1:0] CHIP_LAST   = CW'(PREAMBLE_CHIPS - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(SQUITTER_LENGTH - 1);

`ifdef ADSB_ENC_CRC_EN
    localparam logic [BW-1:0] PAYLOAD_BITS = BW'(SQUITTER_LENGTH - 24);
    localparam logic [23:0]   CRC_POLY     = 24'hFFF409;
`endif

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

    state_t                      state;
    logic [SQUITTER_LENGTH-1:0]  shreg;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] amp;
    logic [SW-1:0]               sample_cnt;
    logic [CW-1:0]               chip_cnt;
    logic [BW-1:0]               bit_cnt;
    logic                        half;      // 0: first chip of bit, 1: second chip
`ifdef ADSB_ENC_CRC_EN
    logic [23:0]                 crc;
    logic [23:0]                 nxt_crc;
`endif

    state_t                      nxt_state;
    logic [SQUITTER_LENGTH-1:0]  nxt_shreg;
    logic [SW-1:0]               nxt_sample;
    logic [CW-1:0]               nxt_chip;
    logic [BW-1:0]               nxt_bit;
    logic                        nxt_half;
    logic                        nxt_bitval;
    logic                        nxt_high;
    logic                        nxt_last;
    logic                        done;

    // Pulses of the preamble land on chips 0, 2, 7 and 9 (0, 1.0, 3.5, 4.5 us).
    function automatic logic preamble_high(input logic [CW-1:0] chip);
        return (chip == CW'(0)) || (chip == CW'(2)) || (chip == CW'(7)) || (chip == CW'(9));
    endfunction

    // Position of the sample that follows the one currently presented, and its level.
    always_comb begin
        nxt_state  = state;
        nxt_shreg  = shreg;
        nxt_sample = sample_cnt;
        nxt_chip   = chip_cnt;
        nxt_bit    = bit_cnt;
        nxt_half   = half;
        nxt_bitval = 1'b0;
        nxt_high   = 1'b0;
        nxt_last   = 1'b0;
        done       = 1'b0;
`ifdef ADSB_ENC_CRC_EN
        nxt_crc    = crc;
`endif
        if (sample_cnt != SAMPLE_LAST) begin
            nxt_sample = sample_cnt + 1'b1;
        end else begin
            nxt_sample = '0;
            case (state)
                PREAMBLE: begin
                    if (chip_cnt == CHIP_LAST) begin
                        nxt_state = DATA;
                        nxt_bit   = '0;
                        nxt_half  = 1'b0;
                    end else begin
                        nxt_chip = chip_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (!half) begin
                        nxt_half = 1'b1;
                    end else begin
                        nxt_half  = 1'b0;
                        nxt_shreg = shreg << 1;
`ifdef ADSB_ENC_CRC_EN
                        if (bit_cnt < PAYLOAD_BITS)
                            nxt_crc = {crc[22:0], 1'b0} ^ ((shreg[SQUITTER_LENGTH-1] ^ crc[23]) ? CRC_POLY : 24'h0);
                        else
                            nxt_crc = {crc[22:0], 1'b0};
`endif
                        if (bit_cnt == BIT_LAST)
                            done = 1'b1;
                        else
                            nxt_bit = bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef ADSB_ENC_CRC_EN
        nxt_bitval = (nxt_bit < PAYLOAD_BITS) ? nxt_shreg[SQUITTER_LENGTH-1] : nxt_crc[23];
`else
        nxt_bitval = nxt_shreg[SQUITTER_LENGTH-1];
`endif
        if (nxt_state == PREAMBLE)
            nxt_high = preamble_high(nxt_chip);
        else
            nxt_high = nxt_half ? ~nxt_bitval : nxt_bitval;
        nxt_last = (nxt_state == DATA) && (nxt_bit == BIT_LAST) && nxt_half && (nxt_sample == SAMPLE_LAST);
    end

    // Frame sequencer: accepts a squitter, then advances one sample per output handshake.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state           <= IDLE;
            shreg           <= '0;
            amp             <= '0;
            sample_cnt      <= '0;
            chip_cnt        <= '0;
            bit_cnt         <= '0;
            half            <= 1'b0;
`ifdef ADSB_ENC_CRC_EN
            crc             <= '0;
`endif
            s00_axis_tready <= 1'b1;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s00_axis_tvalid && s00_axis_tready) begin
                        state           <= PREAMBLE;
                        shreg           <= s00_axis_tdata;
                        amp             <= tx_amplitude;
                        sample_cnt      <= '0;
                        chip_cnt        <= '0;
                        bit_cnt         <= '0;
                        half            <= 1'b0;
`ifdef ADSB_ENC_CRC_EN
                        crc             <= '0;
`endif
                        s00_axis_tready <= 1'b0;
                        busy            <= 1'b1;
                        m00_axis_tvalid <= 1'b1;
                        // Preamble chip 0 is a pulse, so the first sample is the amplitude.
                        m00_axis_tdata  <= tx_amplitude;
                        m00_axis_tlast  <= 1'b0;
                    end
                end
                default: begin
                    if (m00_axis_tvalid && m00_axis_tready) begin
                        if (done) begin
                            state           <= IDLE;
                            sample_cnt      <= '0;
                            chip_cnt        <= '0;
                            bit_cnt         <= '0;
                            half            <= 1'b0;
                            s00_axis_tready <= 1'b1;
                            busy            <= 1'b0;
                            m00_axis_tvalid <= 1'b0;
                            m00_axis_tdata  <= '0;
                            m00_axis_tlast  <= 1'b0;
                        end else begin
                            state          <= nxt_state;
                            shreg          <= nxt_shreg;
                            sample_cnt     <= nxt_sample;
                            chip_cnt       <= nxt_chip;
                            bit_cnt        <= nxt_bit;
                            half           <= nxt_half;
`ifdef ADSB_ENC_CRC_EN
                            crc            <= nxt_crc;
`endif
                            m00_axis_tdata <= nxt_high ? amp : '0;
                            m00_axis_tlast <= nxt_last;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adsb_squitter_encoder.sv
// Directed testbench for adsb_squitter_encoder.
`timescale 1ns/1ps

module tb_adsb_squitter_encoder;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         s_tvalid;
    logic         s_tready;
    logic [111:0] s_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic [31:0]  m_tdata;
    logic         m_tlast;
    logic [31:0]  tx_amp;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] cap     [7680];
    logic [31:0] ref_cap [7680];

    localparam logic [111:0] SQ_REF  = 112'h8D4840D6202CC371C32CE0576098;
    localparam logic [111:0] SQ_ZERO = 112'h0;

    adsb_squitter_encoder dut (
        .s00_axis_aclk    (aclk),
        .s00_axis_aresetn (aresetn),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tlast   (m_tlast),
        .tx_amplitude     (tx_amp),
        .busy             (busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent waveform model: sample index -> magnitude.
    function automatic logic [31:0] exp_sample(input int idx, input logic [111:0] sq, input logic [31:0] amp);
        int  chip;
        int  d;
        logic hi;
        chip = idx / 32;
        if (chip < 16) begin
            hi = (chip == 0) || (chip == 2) || (chip == 7) || (chip == 9);
        end else begin
            d  = chip - 16;
            hi = sq[111 - d / 2];
            if ((d % 2) == 1) hi = !hi;
        end
        return hi ? amp : 32'd0;
    endfunction

    // Threshold receiver at 500: first chip of each bit, mid-chip sample.
    function automatic logic [111:0] decode_cap();
        logic [111:0] r;
        r = '0;
        for (int i = 0; i < 112; i++) r[111 - i] = (cap[512 + i * 64 + 16] > 32'd500);
        return r;
    endfunction

    function automatic int model_errs(input int lo, input int hi, input logic [111:0] sq, input logic [31:0] amp);
        int e;
        e = 0;
        for (int i = lo; i < hi; i++) if (cap[i] !== exp_sample(i, sq, amp)) e++;
        return e;
    endfunction

    // Present a squitter from a falling edge; returns at the falling edge after acceptance.
    task automatic send_squitter(input logic [111:0] sq, input logic [31:0] amp, output bit accepted, output bit first_vld);
        accepted = 1'b0;
        first_vld = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = sq;
        tx_amp   = amp;
        for (int c = 0; c < 16 && !accepted; c++) begin
            if (s_tready) accepted = 1'b1;
            @(negedge aclk);
        end
        s_tvalid  = 1'b0;
        tx_amp    = 32'hDEAD_BEEF;
        first_vld = m_tvalid;
    endtask

    // Collect the frame; returns at the falling edge after the tlast handshake.
    task automatic capture_frame(input bit rnd, output int n, output int nlast, output int lastpos,
                                 output int unstable, output logic mid_tready, output logic mid_busy);
        bit          fin;
        bit          stalled;
        logic [31:0] hd;
        logic        hl;
        n = 0; nlast = 0; lastpos = -1; unstable = 0; fin = 0; stalled = 0;
        hd = '0; hl = 1'b0; mid_tready = 1'bx; mid_busy = 1'bx;
        for (int i = 0; i < 7680; i++) cap[i] = 32'hFFFF_FFFF;
        for (int c = 0; c < 40000 && !fin; c++) begin
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (m_tvalid !== 1'b1 || m_tdata !== hd || m_tlast !== hl)) unstable++;
            if (n == 100) begin mid_tready = s_tready; mid_busy = busy; end
            if (m_tvalid && m_tready) begin
                if (n < 7680) cap[n] = m_tdata;
                if (m_tlast) begin nlast++; lastpos = n; fin = 1'b1; end
                n++;
            end
            if (n >= 7680 && !m_tvalid) fin = 1'b1;
            stalled = m_tvalid && !m_tready;
            hd = m_tdata;
            hl = m_tlast;
            @(negedge aclk);
        end
        m_tready = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1; tx_amp = '0;
        repeat (4) @(negedge aclk);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
        checks++; if (m_tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%0d exp=0", m_tdata); end
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready got=%b exp=1", s_tready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_preamble();
        bit acc, fv; int n, nl, lp, un, e; logic mt, mb;
        send_squitter(SQ_ZERO, 32'd1000, acc, fv);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL pre_accept got=%b exp=1", acc); end
        checks++; if (fv !== 1'b1) begin failures++; $display("FAIL pre_first_valid got=%b exp=1", fv); end
        capture_frame(1'b0, n, nl, lp, un, mt, mb);
        e = model_errs(0, 512, SQ_ZERO, 32'd1000);
        checks++; if (e != 0) begin failures++; $display("FAIL pre_shape bad_samples=%0d exp=0", e); end
        checks++; if (cap[64] !== 32'd1000 || cap[100] !== 32'd0 || cap[288] !== 32'd1000) begin
            failures++; $display("FAIL pre_pulse s64=%0d s100=%0d s288=%0d exp 1000/0/1000", cap[64], cap[100], cap[288]); end
        e = model_errs(512, 7680, SQ_ZERO, 32'd1000);
        checks++; if (e != 0) begin failures++; $display("FAIL zero_data bad_samples=%0d exp=0", e); end
        checks++; if (mt !== 1'b0) begin failures++; $display("FAIL mid_s_tready got=%b exp=0", mt); end
        checks++; if (mb !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", mb); end
        checks++; if (busy !== 1'b0 || s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            failures++; $display("FAIL post_frame busy=%b s_tready=%b tvalid=%b exp 0/1/0", busy, s_tready, m_tvalid); end
    endtask

    task automatic test_data();
        bit acc, fv; int n, nl, lp, un, e; logic mt, mb; logic [111:0] dec;
        send_squitter(SQ_REF, 32'd1000, acc, fv);
        capture_frame(1'b0, n, nl, lp, un, mt, mb);
        checks++; if (cap[512] !== 32'd1000 || cap[543] !== 32'd1000) begin failures++; $display("FAIL bit1_first s512=%0d s543=%0d exp=1000", cap[512], cap[543]); end
        checks++; if (cap[544] !== 32'd0 || cap[575] !== 32'd0) begin failures++; $display("FAIL bit1_second s544=%0d s575=%0d exp=0", cap[544], cap[575]); end
        checks++; if (cap[576] !== 32'd0 || cap[607] !== 32'd0) begin failures++; $display("FAIL bit0_first s576=%0d s607=%0d exp=0", cap[576], cap[607]); end
        checks++; if (cap[608] !== 32'd1000 || cap[639] !== 32'd1000) begin failures++; $display("FAIL bit0_second s608=%0d s639=%0d exp=1000", cap[608], cap[639]); end
        checks++; if (n != 7680) begin failures++; $display("FAIL data_count got=%0d exp=7680", n); end
        checks++; if (nl != 1 || lp != 7679) begin failures++; $display("FAIL data_tlast count=%0d pos=%0d exp 1 at 7679", nl, lp); end
        e = model_errs(0, 7680, SQ_REF, 32'd1000);
        checks++; if (e != 0) begin failures++; $display("FAIL data_wave bad_samples=%0d exp=0", e); end
        dec = decode_cap();
        checks++; if (dec !== SQ_REF) begin failures++; $display("FAIL data_roundtrip got=%h exp=%h", dec, SQ_REF); end
        for (int i = 0; i < 7680; i++) ref_cap[i] = cap[i];
    endtask

    task automatic test_backpressure();
        bit acc, fv; int n, nl, lp, un, e; logic mt, mb;
        send_squitter(SQ_REF, 32'd1000, acc, fv);
        capture_frame(1'b1, n, nl, lp, un, mt, mb);
        e = 0;
        for (int i = 0; i < 7680; i++) if (cap[i] !== ref_cap[i]) e++;
        checks++; if (n != 7680) begin failures++; $display("FAIL bp_count got=%0d exp=7680", n); end
        checks++; if (e != 0) begin failures++; $display("FAIL bp_sequence diff_samples=%0d exp=0", e); end
        checks++; if (un != 0) begin failures++; $display("FAIL bp_stall_stable changes=%0d exp=0", un); end
        checks++; if (nl != 1 || lp != 7679) begin failures++; $display("FAIL bp_tlast count=%0d pos=%0d exp 1 at 7679", nl, lp); end
    endtask

`ifdef ADSB_ENC_CRC_EN
    task automatic test_crc();
        bit acc, fv; int n, nl, lp, un, e; logic mt, mb; logic [111:0] dec;
        send_squitter(112'h8D4840D6202CC371C32CE0_000000, 32'd1000, acc, fv);
        capture_frame(1'b0, n, nl, lp, un, mt, mb);
        dec = decode_cap();
        checks++; if (dec !== SQ_REF) begin failures++; $display("FAIL crc_bits got=%h exp=%h", dec, SQ_REF); end
        e = model_errs(0, 7680, SQ_REF, 32'd1000);
        checks++; if (e != 0) begin failures++; $display("FAIL crc_wave bad_samples=%0d exp=0", e); end
    endtask
`endif

    task automatic test_abort();
        bit acc, fv;
        send_squitter(SQ_REF, 32'd1000, acc, fv);
        m_tready = 1'b1;
        repeat (3000) @(negedge aclk);
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== exp_sample(3000, SQ_REF, 32'd1000)) begin
            failures++; $display("FAIL abort_pre tvalid=%b tdata=%0d exp 1/%0d", m_tvalid, m_tdata, exp_sample(3000, SQ_REF, 32'd1000)); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'd0) begin
            failures++; $display("FAIL abort_outputs tvalid=%b tlast=%b tdata=%0d exp 0/0/0", m_tvalid, m_tlast, m_tdata); end
        checks++; if (s_tready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_idle s_tready=%b busy=%b exp 1/0", s_tready, busy); end
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL abort_stays_idle tvalid=%b exp=0", m_tvalid); end
    endtask

    task automatic test_back_to_back();
        bit acc, fv; int n, nl, lp, un, e; logic mt, mb;
        send_squitter(SQ_REF, 32'd1000, acc, fv);
        s_tvalid = 1'b1;
        s_tdata  = SQ_ZERO;
        tx_amp   = 32'd2000;
        capture_frame(1'b0, n, nl, lp, un, mt, mb);
        checks++; if (n != 7680 || lp != 7679) begin failures++; $display("FAIL b2b_first count=%0d lastpos=%0d exp 7680/7679", n, lp); end
        checks++; if (s_tready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_accept_cycle s_tready=%b busy=%b exp 1/0", s_tready, busy); end
        @(negedge aclk);
        s_tvalid = 1'b0;
        tx_amp   = 32'hDEAD_BEEF;
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd2000 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_first_sample tvalid=%b tdata=%0d busy=%b exp 1/2000/1", m_tvalid, m_tdata, busy); end
        capture_frame(1'b0, n, nl, lp, un, mt, mb);
        e = model_errs(0, 7680, SQ_ZERO, 32'd2000);
        checks++; if (n != 7680 || e != 0) begin failures++; $display("FAIL b2b_second count=%0d bad_samples=%0d exp 7680/0", n, e); end
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_data();
        test_backpressure();
`ifdef ADSB_ENC_CRC_EN
        test_crc();
`endif
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adsb_squitter_encoder.md
Name: adsb_squitter_encoder

Overview:
Transmit-side counterpart of the ADS-B receive chain. Accepts one 112-bit Mode-S extended squitter per AXI-Stream transfer and emits the baseband pulse-position waveform as a 64 MSps magnitude sample stream: an 8 us preamble followed by 112 Manchester-coded data bits. Output feeds the DAC/loopback path and can drive the existing magnitude-threshold receiver directly for closed-loop test.

Parameters:
SQUITTER_LENGTH, 112, data bits per frame
CHIP_LENGTH, 32, samples per 0.5 us chip at 64 MSps
PREAMBLE_CHIPS, 16, preamble length in chips (8 us)
C_S00_AXIS_TDATA_WIDTH, SQUITTER_LENGTH, input squitter width
C_M00_AXIS_TDATA_WIDTH, 32, output sample width

Ports:
s00_axis_aclk  input  1  clock
s00_axis_aresetn  input  1  synchronous active-low reset
s00_axis_tvalid  input  1  squitter valid
s00_axis_tready  output  1  encoder can accept a squitter
s00_axis_tdata  input  112  squitter, bit 111 transmitted first
m00_axis_tvalid  output  1  sample valid
m00_axis_tready  input  1  downstream ready (honoured)
m00_axis_tdata  output  32  sample magnitude
m00_axis_tlast  output  1  final sample of frame
tx_amplitude  input  32  high-chip magnitude, captured at squitter acceptance
busy  output  1  frame in progress

Behaviour:
- Reset (aresetn low at clock edge): state IDLE; s00_axis_tready=1, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, busy=0; all counters and shift register cleared. Reset mid-frame aborts immediately; no tlast emitted.
- States: IDLE, PREAMBLE, DATA.
- IDLE: tready=1. On s00 tvalid&&tready: latch tdata into shift register, latch tx_amplitude, clear sample/chip/bit counters, go PREAMBLE. First sample valid the next cycle (1-cycle latency). tready=0 in PREAMBLE and DATA; back-to-back frame accepted in the cycle after the tlast handshake.
- Sample advance: counters advance only on m00 tvalid&&tready. While tvalid&&!tready, tdata/tlast held stable.
- Sample value: tx_amplitude if current chip is high, else 0.
- PREAMBLE: chips 0..15; high chips 0, 2, 7, 9 (pulses at 0, 1.0, 3.5, 4.5 us), others low. After last sample of chip 15 -> DATA.
- DATA: each bit = two chips. Bit 1 -> high,low; bit 0 -> low,high. Shift register shifts left once per bit, after final sample of second chip. After bit SQUITTER_LENGTH-1 completes -> IDLE.
- tlast=1 only on sample index 7679 (frame length (16+224)*32 = 7680 samples).
- sample_counter wraps 0..CHIP_LENGTH-1; counter widths via $clog2, no overflow at boundaries.
- busy=1 from the cycle after acceptance through the tlast handshake cycle.
- Simultaneous s00 tvalid during a frame: ignored (tready=0); input must hold until accepted.

Optional Feature:
ADSB_ENC_CRC_EN
- Defined: only s00_axis_tdata[111:24] (88-bit payload) is used; the encoder generates the 24 parity bits. CRC-24 register, init 0, poly 0xFFF409; per payload bit b at that bit's completion: fb=b^crc[23]; crc=(crc<<1)^(fb?24'hFFF409:0). Bits 88..111 transmit crc[23] MSB-first, shifting crc left per bit. Input [23:0] ignored.
- Undefined: all 112 input bits transmitted verbatim; no CRC logic.

Test Plan:
- Reset then idle: aresetn low 4 cycles -> tvalid=0, tlast=0, tdata=0, s00_tready=1, busy=0.
- Preamble shape: squitter all-zero, tx_amplitude=1000, tready=1 -> samples 0-31, 64-95, 224-255, 288-319 =1000; other samples 0-511 =0.
- Data coding: squitter 0x8D4840D6202CC371C32CE0576098, macro off -> sample 512-543 =1000, 544-575 =0 (bit 1); 576-607 =0, 608-639 =1000 (bit 0); tlast only at sample 7679; 7680 samples total; round-trip through the receiver at threshold 500 returns the same 112 bits.
- Backpressure: random 50% m00 tready -> sample sequence identical to the tready=1 run; tdata/tlast stable while stalled.
- CRC: macro on, input 0x8D4840D6202CC371C32CE0_000000 -> transmitted bits equal 0x8D4840D6202CC371C32CE0576098.
- Abort/back-to-back: aresetn low at sample 3000 -> tvalid=0 next cycle, IDLE. Two frames queued -> second accepted in the cycle after the first tlast handshake, and its first sample follows one cycle later.
